// File: rtl/data_mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_dump_ctrl
//   End-of-simulation readback engine. A start pulse takes the data-memory port
//   away from the datapath. The block then reads NUM_WORDS words from BASE_ADDR
//   upward in steps of 4 and hands each word, with its address, to an output
//   sink over a valid/ready handshake. When the last word is accepted, the port
//   goes back to the datapath.
//
// Parameters
//   BASE_ADDR  byte address of the first word dumped (word aligned)
//   NUM_WORDS  number of words to dump, 1..65535
//   RD_LAT     data-memory read latency in cycles, 1..4
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   one-cycle pulse; only honoured in IDLE or DONE
//   busy       out  1   high from GRANT through PUSH
//   done       out  1   high in DONE
//   mem_grant  out  1   1 = this block drives data memory, 0 = datapath does
//   mem_rd     out  1   read strobe, active-high
//   mem_wr_n   out  1   write strobe, active-low; tied inactive
//   mem_addr   out  32  byte address to data memory
//   mem_rdata  in   32  data-memory read data
//   out_valid  out  1   out_data/out_addr valid
//   out_ready  in   1   sink accepts on out_valid & out_ready at a rising edge
//   out_data   out  32  dumped word
//   out_addr   out  32  byte address of out_data
//   word_cnt   out  16  words accepted by the sink in the current dump
// -----------------------------------------------------------------------------
module data_mem_dump_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        mem_grant,
  output logic        mem_rd,
  output logic        mem_wr_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_t;

  // Final WAIT cycle index and final word count, both as fixed-width compares.
  localparam logic [1:0]  WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [15:0] CNT_LAST  = 16'(NUM_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ptr;
  logic [1:0]  wait_cnt;

  logic wait_last;
  logic word_last;
  logic accept;

  assign wait_last = (wait_cnt == WAIT_LAST);
  assign word_last = (word_cnt == CNT_LAST);
  assign accept    = (state == S_PUSH) && out_ready;

  // Next-state logic.
  always_comb begin
    // NOTE: state_nxt gets a default before the case so every path assigns
    // it; a missing branch would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_last) state_nxt = S_PUSH;
      S_PUSH:  if (out_ready) state_nxt = word_last ? S_DONE : S_READ;
      S_DONE:  if (start) state_nxt = S_GRANT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= BASE_ADDR;
      wait_cnt <= '0;
      out_data <= '0;
      out_addr <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_GRANT: begin
          ptr      <= BASE_ADDR;
          word_cnt <= '0;
        end
        S_READ: wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          // Read data is valid during the final WAIT cycle only.
          if (wait_last) begin
            out_data <= mem_rdata;
            out_addr <= ptr;
          end
        end
        S_PUSH: begin
          if (accept) begin
            word_cnt <= word_cnt + 16'd1;
            // 32-bit wrap past 32'hFFFF_FFFC to 0 is intended.
            ptr      <= ptr + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are a pure decode of the registered state.
  assign busy      = (state == S_GRANT) || (state == S_READ) ||
                     (state == S_WAIT)  || (state == S_PUSH);
  assign done      = (state == S_DONE);
  assign mem_grant = busy;
  assign mem_rd    = (state == S_READ);
  assign mem_wr_n  = 1'b1;
  assign mem_addr  = ptr;
  assign out_valid = (state == S_PUSH);

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_dump_ctrl
//   Directed bench for data_mem_dump_ctrl. Instance u_a uses the default base
//   with NUM_WORDS=4, RD_LAT=1; instance u_b uses base 32'hFFFF_FFF8 with
//   NUM_WORDS=3, RD_LAT=3 to cover address wrap and longer read latency.
//   Memory word at address a is 32'hA5A5_0000 + (a - base)/4.
// -----------------------------------------------------------------------------
module tb_data_mem_dump_ctrl;

  localparam logic [31:0] BASE_A = 32'h1001_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;
  localparam int          NW_A   = 4;
  localparam int          NW_B   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A signals
  logic        start_a, ready_a;
  logic        busy_a, done_a, mem_grant_a, mem_rd_a, mem_wr_n_a, out_valid_a;
  logic [31:0] mem_addr_a, mem_rdata_a, out_data_a, out_addr_a;
  logic [15:0] word_cnt_a;

  // DUT B signals
  logic        start_b, ready_b;
  logic        busy_b, done_b, mem_grant_b, mem_rd_b, mem_wr_n_b, out_valid_b;
  logic [31:0] mem_addr_b, mem_rdata_b, out_data_b, out_addr_b;
  logic [15:0] word_cnt_b;

  data_mem_dump_ctrl #(.BASE_ADDR(BASE_A), .NUM_WORDS(NW_A), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_grant(mem_grant_a), .mem_rd(mem_rd_a), .mem_wr_n(mem_wr_n_a),
    .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .out_valid(out_valid_a),
    .out_ready(ready_a), .out_data(out_data_a), .out_addr(out_addr_a),
    .word_cnt(word_cnt_a)
  );

  data_mem_dump_ctrl #(.BASE_ADDR(BASE_B), .NUM_WORDS(NW_B), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_grant(mem_grant_b), .mem_rd(mem_rd_b), .mem_wr_n(mem_wr_n_b),
    .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .out_valid(out_valid_b),
    .out_ready(ready_b), .out_data(out_data_b), .out_addr(out_addr_b),
    .word_cnt(word_cnt_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] d;
    d = (a - base) >> 2;
    return 32'hA5A5_0000 + {16'h0, d[15:0]};
  endfunction

  // Memory models: data only appears after RD_LAT edges of a real read.
  logic [31:0] pa;
  logic [31:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    pa  <= mem_rd_a ? mem_word(mem_addr_a, BASE_A) : 32'hDEAD_BEEF;
    pb0 <= mem_rd_b ? mem_word(mem_addr_b, BASE_B) : 32'hDEAD_BEEF;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_rdata_a = pa;
  assign mem_rdata_b = pb2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sinks: record accepted transfers; check hold-while-stalled and latency.
  logic [63:0] acc_a[$];
  logic [63:0] acc_b[$];
  logic        prev_valid_a = 1'b0, prev_acc_a = 1'b0;
  logic [31:0] prev_data_a, prev_addr_a;
  logic        prev_valid_b = 1'b0;
  int          rd_cyc_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid_a = 1'b0;
      prev_valid_b = 1'b0;
    end else begin
      if (out_valid_a && prev_valid_a && !prev_acc_a) begin
        check("hold_data", out_data_a, prev_data_a);
        check("hold_addr", out_addr_a, prev_addr_a);
      end
      if (out_valid_a) check("grant_in_push", {31'b0, mem_grant_a}, 32'd1);
      if (out_valid_a && ready_a) acc_a.push_back({out_addr_a, out_data_a});
      prev_valid_a = out_valid_a;
      prev_acc_a   = out_valid_a && ready_a;
      prev_data_a  = out_data_a;
      prev_addr_a  = out_addr_a;

      if (busy_b) check("wr_n_b", {31'b0, mem_wr_n_b}, 32'd1);
      if (mem_rd_b) rd_cyc_b = cyc;
      // READ cycle, three WAIT cycles, then PUSH.
      if (out_valid_b && !prev_valid_b) check("lat_b", 32'(cyc - rd_cyc_b), 32'd4);
      if (out_valid_b && ready_b) acc_b.push_back({out_addr_b, out_data_b});
      prev_valid_b = out_valid_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 200) begin tick(); n++; end
    check("done_a_timeout", {31'b0, done_a}, 32'd1);
  endtask

  task automatic wait_read_a(input logic [31:0] addr);
    int n = 0;
    while (!(mem_rd_a && mem_addr_a == addr) && n < 100) begin tick(); n++; end
    check("read_a_timeout", {31'b0, mem_rd_a}, 32'd1);
  endtask

  task automatic wait_push_a();
    int n = 0;
    while (!out_valid_a && n < 100) begin tick(); n++; end
    check("push_a_timeout", {31'b0, out_valid_a}, 32'd1);
  endtask

  task automatic check_dump_a(input string tag);
    check({tag, "_n"}, 32'(acc_a.size()), NW_A);
    for (int k = 0; k < NW_A; k++) begin
      if (k < acc_a.size()) begin
        check({tag, "_addr"}, acc_a[k][63:32], BASE_A + 32'(4 * k));
        check({tag, "_data"}, acc_a[k][31:0], 32'hA5A5_0000 + 32'(k));
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;

    // T1: reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_busy",   {31'b0, busy_a},      32'd0);
    check("rst_done",   {31'b0, done_a},      32'd0);
    check("rst_grant",  {31'b0, mem_grant_a}, 32'd0);
    check("rst_rd",     {31'b0, mem_rd_a},    32'd0);
    check("rst_wr_n",   {31'b0, mem_wr_n_a},  32'd1);
    check("rst_valid",  {31'b0, out_valid_a}, 32'd0);
    check("rst_addr",   mem_addr_a,           BASE_A);
    check("rst_odata",  out_data_a,           32'd0);
    check("rst_oaddr",  out_addr_a,           32'd0);
    check("rst_wcnt",   {16'b0, word_cnt_a},  32'd0);
    check("rst_addr_b", mem_addr_b,           BASE_B);

    // T2: plain dump, done 13 cycles after the start edge
    acc_a.delete();
    pulse_start_a();
    check("grant_busy", {31'b0, busy_a},      32'd1);
    check("grant_mg",   {31'b0, mem_grant_a}, 32'd1);
    check("grant_rd",   {31'b0, mem_rd_a},    32'd0);
    tick();
    check("read0_rd",   {31'b0, mem_rd_a},    32'd1);
    check("read0_addr", mem_addr_a,           BASE_A);
    for (int i = 2; i <= 13; i++) begin
      tick();
      if (i == 12) check("done_early", {31'b0, done_a}, 32'd0);
      if (i == 13) check("done_at13",  {31'b0, done_a}, 32'd1);
    end
    check("t2_grant_off", {31'b0, mem_grant_a}, 32'd0);
    check("t2_wcnt",      {16'b0, word_cnt_a},  32'd4);
    check_dump_a("t2");

    // T3: sink stalls 5 cycles on word 2
    acc_a.delete();
    pulse_start_a();
    wait_read_a(BASE_A + 32'd8);
    ready_a = 1'b0;
    wait_push_a();
    repeat (5) begin
      check("stall_valid", {31'b0, out_valid_a}, 32'd1);
      check("stall_data",  out_data_a,           32'hA5A5_0002);
      check("stall_addr",  out_addr_a,           BASE_A + 32'd8);
      check("stall_grant", {31'b0, mem_grant_a}, 32'd1);
      check("stall_wcnt",  {16'b0, word_cnt_a},  32'd2);
      tick();
    end
    ready_a = 1'b1;
    wait_done_a();
    check("t3_wcnt", {16'b0, word_cnt_a}, 32'd4);
    check_dump_a("t3");

    // T4: start while busy is ignored; start in DONE restarts
    acc_a.delete();
    pulse_start_a();
    check("t4_done_clr", {31'b0, done_a}, 32'd0);
    tick();
    check("t4_wcnt0", {16'b0, word_cnt_a}, 32'd0);
    wait_read_a(BASE_A + 32'd4);
    pulse_start_a();
    wait_push_a();
    pulse_start_a();
    wait_done_a();
    check("t4_wcnt", {16'b0, word_cnt_a}, 32'd4);
    check_dump_a("t4a");
    acc_a.delete();
    pulse_start_a();
    tick();
    check("t4_restart_wcnt", {16'b0, word_cnt_a}, 32'd0);
    wait_done_a();
    check_dump_a("t4b");

    // T5: reset during WAIT of word 2
    acc_a.delete();
    pulse_start_a();
    wait_read_a(BASE_A + 32'd8);
    tick();
    rst = 1'b1;
    tick();
    check("t5_busy",  {31'b0, busy_a},      32'd0);
    check("t5_grant", {31'b0, mem_grant_a}, 32'd0);
    check("t5_valid", {31'b0, out_valid_a}, 32'd0);
    check("t5_done",  {31'b0, done_a},      32'd0);
    check("t5_wcnt",  {16'b0, word_cnt_a},  32'd0);
    check("t5_addr",  mem_addr_a,           BASE_A);
    rst = 1'b0;
    tick();
    acc_a.delete();
    pulse_start_a();
    wait_done_a();
    check_dump_a("t5");

    // T6: wrap past 32'hFFFF_FFFC with RD_LAT=3
    acc_b.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    begin
      int n = 0;
      while (!done_b && n < 200) begin tick(); n++; end
    end
    check("t6_done", {31'b0, done_b}, 32'd1);
    check("t6_n", 32'(acc_b.size()), NW_B);
    for (int k = 0; k < NW_B; k++) begin
      if (k < acc_b.size()) begin
        check("t6_addr", acc_b[k][63:32], BASE_B + 32'(4 * k));
        check("t6_data", acc_b[k][31:0],  32'hA5A5_0000 + 32'(k));
      end
    end
    check("t6_wcnt", {16'b0, word_cnt_b}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
